mmio_uart_tx: RTL and testbench

//  Memory-mapped responder on the processor data bus (MemWrite/DataAdr/WriteData). Stores to its

---
 rtl/mmio_uart_tx_pkg.sv | 26 ++
 rtl/mmio_uart_tx_if.sv | 11 +
 rtl/mmio_uart_tx_sync_fifo.sv | 43 ++++
 rtl/mmio_uart_tx.sv | 142 ++++++++++++++
 tb/tb_mmio_uart_tx.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: address map,
// STATUS layout and serializer state encodings.
package mmio_uart_tx_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'hFFFF_0000;

  // Register select is DataAdr[2] inside the 8-byte window.
  localparam logic REG_TXDATA = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  // STATUS[3:0]; the field order gives the bit positions.
  typedef struct packed {
    logic overflow;
    logic fifo_empty;
    logic fifo_full;
    logic busy;
  } status_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Processor data-bus slice seen by the UART: store strobe, address, data, load return.
interface mmio_uart_tx_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        sel;

  modport master (output MemWrite, DataAdr, WriteData, input ReadData, sel);
  modport slave  (input MemWrite, DataAdr, WriteData, output ReadData, sel);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a pop lets a push into a full FIFO proceed.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA stores feed a FIFO drained by a
// START/DATA/STOP serializer; STATUS reports overflow, FIFO state and busy.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = BASE_ADDR_DEFAULT,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  mmio_uart_tx_if.slave  bus,
  output logic           tx,
  output logic           irq
);
  localparam int             BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;

  logic          push_req, clr_req, fifo_pop, fifo_full, fifo_empty, baud_last, busy;
  logic [7:0]    fifo_dout;
  status_t       status;
  logic          unused_bits;

  assign bus.sel     = (bus.DataAdr[31:3] == BASE_ADDR[31:3]);
  assign push_req    = bus.MemWrite && bus.sel && (bus.DataAdr[2] == REG_TXDATA);
  assign clr_req     = bus.MemWrite && bus.sel && (bus.DataAdr[2] == REG_STATUS) && bus.WriteData[3];
  assign unused_bits = ^{bus.WriteData[31:8], bus.DataAdr[1:0]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_req),
    .pop_i   (fifo_pop),
    .din_i   (bus.WriteData[7:0]),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign busy         = (state_q != ST_IDLE);
  assign status       = {ovf_q, fifo_empty, fifo_full, busy};
  assign bus.ReadData = (bus.sel && (bus.DataAdr[2] == REG_STATUS)) ? {28'b0, status} : 32'b0;
  assign irq          = fifo_empty && !busy;
  assign tx           = tx_q;
  assign baud_last    = (baud_q == BAUD_LAST);

  // A same-cycle set beats the clear; a pop frees the slot so a push into full is not lost.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_req) ovf_d = 1'b0;
    if (push_req && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  // NOTE: every output of this block gets a default first so no latch can be inferred.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = '0;
          tx_d     = 1'b0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        baud_d = baud_q + BW'(1);
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        baud_d = baud_q + BW'(1);
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      ST_STOP: begin
        baud_d = baud_q + BW'(1);
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next frame so back-to-back bytes have no idle gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            tx_d     = 1'b0;
            state_d  = ST_START;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4; the serial line
// is logged on falling edges and compared against hand-derived 8N1 frames.
module tb_mmio_uart_tx;

  logic clk;
  logic reset;
  logic tx;
  logic irq;

  mmio_uart_tx_if bus_if();

  mmio_uart_tx #(
    .BASE_ADDR    (32'hFFFF_0000),
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .tx    (tx),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic cap_en   = 1'b0;
  logic tx_log[$];
  logic irq_log[$];
  logic busy_log[$];

  always @(negedge clk) begin
    if (cap_en) begin
      tx_log.push_back(tx);
      irq_log.push_back(irq);
      busy_log.push_back(bus_if.ReadData[0]);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Start bit, 8 data bits LSB first, stop bit; 4 clocks each, bit i = sample i.
  function automatic logic [39:0] frame_of(input logic [7:0] b);
    logic [39:0] v;
    v = '0;
    for (int j = 0; j < 8; j++) v[4 + 4*j +: 4] = {4{b[j]}};
    v[39:36] = 4'hF;
    return v;
  endfunction

  function automatic logic [63:0] log_vec(input int which, input int start, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) begin
      if (start + i < tx_log.size()) begin
        case (which)
          0:       v[i] = tx_log[start + i];
          1:       v[i] = irq_log[start + i];
          default: v[i] = busy_log[start + i];
        endcase
      end
    end
    return v;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.MemWrite  = 1'b1;
    bus_if.DataAdr   = a;
    bus_if.WriteData = d;
    @(posedge clk);
    #1;
    bus_if.MemWrite = 1'b0;
  endtask

  task automatic rd_status(output logic [31:0] v);
    bus_if.DataAdr = 32'hFFFF_0004;
    #1;
    v = bus_if.ReadData;
  endtask

  task automatic start_cap();
    tx_log.delete();
    irq_log.delete();
    busy_log.delete();
    cap_en = 1'b1;
  endtask

  task automatic wait_samples(input int n);
    int cyc;
    cyc = 0;
    while (tx_log.size() < n && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    cap_en = 1'b0;
    check("capture_length", 64'(tx_log.size()), 64'(n));
  endtask

  logic [31:0] st;

  initial begin
    reset            = 1'b0;
    bus_if.MemWrite  = 1'b0;
    bus_if.DataAdr   = 32'hFFFF_0004;
    bus_if.WriteData = 32'h0;

    // 1: reset state and address decode.
    repeat (2) @(posedge clk);
    #2;
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_irq", 64'(irq), 64'd1);
    rd_status(st);
    check("rst_status", 64'(st), 64'h4);
    check("sel_status", 64'(bus_if.sel), 64'd1);
    bus_if.DataAdr = 32'hFFFF_0000;
    #1;
    check("txdata_reads_zero", 64'(bus_if.ReadData), 64'h0);
    bus_if.DataAdr = 32'hFFFE_0004;
    #1;
    check("sel_other", 64'(bus_if.sel), 64'd0);
    check("other_reads_zero", 64'(bus_if.ReadData), 64'h0);
    @(negedge clk);
    reset = 1'b1;

    // 2: single byte frame, latency, busy and irq.
    wr(32'hFFFF_0000, 32'h1234_56A5);
    bus_if.DataAdr = 32'hFFFF_0004;
    start_cap();
    wait_samples(42);
    check("t2_pre_idle", log_vec(0, 0, 1), 64'd1);
    check("t2_frame_a5", log_vec(0, 1, 40), 64'(frame_of(8'hA5)));
    check("t2_post_idle", log_vec(0, 41, 1), 64'd1);
    check("t2_busy", log_vec(2, 0, 42), 64'({1'b0, {40{1'b1}}, 1'b0}));
    check("t2_irq", log_vec(1, 0, 42), 64'({1'b1, 41'b0}));
    rd_status(st);
    check("t2_status_end", 64'(st), 64'h4);

    // 3: six stores, FIFO fills, sixth dropped, five frames back to back.
    wr(32'hFFFF_0000, 32'h01);
    start_cap();
    for (int k = 2; k <= 6; k++) wr(32'hFFFF_0000, 32'(k));
    rd_status(st);
    check("t3_status_ovf_full_busy", 64'(st), 64'hB);
    wait_samples(202);
    check("t3_pre_idle", log_vec(0, 0, 1), 64'd1);
    for (int k = 0; k < 5; k++)
      check($sformatf("t3_frame_%0d", k + 1), log_vec(0, 1 + 40*k, 40), 64'(frame_of(8'(k + 1))));
    check("t3_post_idle", log_vec(0, 201, 1), 64'd1);
    check("t3_irq_end", log_vec(1, 201, 1), 64'd1);
    rd_status(st);
    check("t3_status_end", 64'(st), 64'hC);

    // 4: overflow clear needs WriteData[3]; out-of-window and misaligned stores.
    wr(32'hFFFF_0004, 32'h7);
    rd_status(st);
    check("t4_no_clear_bit3_low", 64'(st), 64'hC);
    wr(32'hFFFF_0004, 32'h8);
    rd_status(st);
    check("t4_clear", 64'(st), 64'h4);
    wr(32'hFFFF_0008, 32'h55);
    check("t4_outside_sel", 64'(bus_if.sel), 64'd0);
    check("t4_outside_rdata", 64'(bus_if.ReadData), 64'h0);
    rd_status(st);
    check("t4_outside_no_push", 64'(st), 64'h4);
    repeat (3) @(negedge clk);
    check("t4_outside_line_idle", 64'(tx), 64'd1);
    wr(32'hFFFF_0001, 32'hFFFF_FF3C);
    start_cap();
    wait_samples(42);
    check("t4_misaligned_frame", log_vec(0, 1, 40), 64'(frame_of(8'h3C)));

    // 5: full FIFO, store on the STOP->START pop edge is accepted.
    wr(32'hFFFF_0000, 32'h10);
    start_cap();
    for (int k = 1; k <= 4; k++) wr(32'hFFFF_0000, 32'(8'h10 + k));
    repeat (36) @(posedge clk);
    wr(32'hFFFF_0000, 32'h15);
    rd_status(st);
    check("t5_status_full_no_ovf", 64'(st), 64'h3);
    wait_samples(242);
    for (int k = 0; k < 6; k++)
      check($sformatf("t5_frame_%0d", k), log_vec(0, 1 + 40*k, 40), 64'(frame_of(8'(8'h10 + k))));
    rd_status(st);
    check("t5_status_end", 64'(st), 64'h4);

    // 6: reset during data bit 3 abandons the frame and the queued byte.
    wr(32'hFFFF_0000, 32'hC3);
    wr(32'hFFFF_0000, 32'h99);
    repeat (17) @(posedge clk);
    #2;
    check("t6_bit3_low", 64'(tx), 64'd0);
    reset = 1'b0;
    #1;
    check("t6_rst_tx", 64'(tx), 64'd1);
    check("t6_rst_irq", 64'(irq), 64'd1);
    rd_status(st);
    check("t6_rst_status", 64'(st), 64'h4);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_line_idle", 64'(tx), 64'd1);
    wr(32'hFFFF_0000, 32'h5A);
    start_cap();
    wait_samples(42);
    check("t6_clean_frame", log_vec(0, 1, 40), 64'(frame_of(8'h5A)));
    check("t6_post_idle", log_vec(0, 41, 1), 64'd1);
    check("t6_irq_end", log_vec(1, 41, 1), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
